// File: rtl/parking_gate_controller.sv
// Entry/exit barrier controller feeding the parking occupancy counter with serialised car events.
// Optional GATE_STATS_EN adds saturating denied/timeout statistics counters.
`timescale 1ns/1ps

module parking_gate_controller #(
    parameter int unsigned GATE_TIMEOUT = 16,
    parameter int unsigned TMO_W        = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        entry_request,
    input  logic        entry_is_uni,
    input  logic        entry_passed,
    input  logic        exit_request,
    input  logic        exit_is_uni,
    input  logic        exit_passed,
    input  logic        uni_is_vacated_space,
    input  logic        is_vacated_space,
    output logic        entry_gate_open,
    output logic        exit_gate_open,
    output logic        entry_denied,
    output logic        car_entered,
    output logic        is_uni_car_entered,
    output logic        car_exited,
    output logic        is_uni_car_exited
`ifdef GATE_STATS_EN
    ,
    output logic [15:0] denied_count,
    output logic [15:0] timeout_count
`endif
);

    typedef enum logic [1:0] {E_IDLE, E_CHECK, E_OPEN, E_REPORT} entry_state_t;
    typedef enum logic [1:0] {X_IDLE, X_OPEN, X_REPORT} exit_state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GATE_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

    entry_state_t     entry_state, entry_next;
    exit_state_t      exit_state, exit_next;
    logic             entry_uni, exit_uni;
    logic [TMO_W-1:0] entry_tmr, exit_tmr;
    logic             entry_space;
    logic             entry_timeout, exit_timeout;

    assign entry_space   = entry_uni ? uni_is_vacated_space : is_vacated_space;
    // A pass on the final open cycle still wins over the timeout.
    assign entry_timeout = (entry_state == E_OPEN) && !entry_passed && (entry_tmr == TMO_LAST);
    assign exit_timeout  = (exit_state == X_OPEN) && !exit_passed && (exit_tmr == TMO_LAST);

    // State register, pool latches and open timers.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_state <= E_IDLE;
            exit_state  <= X_IDLE;
            entry_uni   <= 1'b0;
            exit_uni    <= 1'b0;
            entry_tmr   <= '0;
            exit_tmr    <= '0;
        end else begin
            entry_state <= entry_next;
            exit_state  <= exit_next;
            if (entry_state == E_IDLE && entry_request) entry_uni <= entry_is_uni;
            if (exit_state == X_IDLE && exit_request)   exit_uni  <= exit_is_uni;

            if (entry_state != E_OPEN && entry_next == E_OPEN)
                entry_tmr <= '0;
            else if (entry_state == E_OPEN && entry_tmr != TMO_MAX)
                entry_tmr <= entry_tmr + TMO_W'(1);

            if (exit_state != X_OPEN && exit_next == X_OPEN)
                exit_tmr <= '0;
            else if (exit_state == X_OPEN && exit_tmr != TMO_MAX)
                exit_tmr <= exit_tmr + TMO_W'(1);
        end
    end

    // Next-state logic for both barriers.
    always_comb begin
        entry_next = entry_state;
        exit_next  = exit_state;

        case (entry_state)
            E_IDLE:   if (entry_request) entry_next = E_CHECK;
            E_CHECK:  entry_next = entry_space ? E_OPEN : E_IDLE;
            E_OPEN: begin
                if (entry_passed)       entry_next = E_REPORT;
                else if (entry_timeout) entry_next = E_IDLE;
            end
            E_REPORT: entry_next = E_IDLE;
            default:  entry_next = E_IDLE;
        endcase

        case (exit_state)
            X_IDLE:   if (exit_request) exit_next = X_OPEN;
            X_OPEN: begin
                if (exit_passed)       exit_next = X_REPORT;
                else if (exit_timeout) exit_next = X_IDLE;
            end
            // Exit waits here while entry owns the event slot.
            X_REPORT: if (entry_state != E_REPORT) exit_next = X_IDLE;
            default:  exit_next = X_IDLE;
        endcase
    end

    // Output decode; entry wins the shared event slot.
    always_comb begin
        entry_gate_open    = 1'b0;
        exit_gate_open     = 1'b0;
        entry_denied       = 1'b0;
        car_entered        = 1'b0;
        is_uni_car_entered = 1'b0;
        car_exited         = 1'b0;
        is_uni_car_exited  = 1'b0;

        entry_gate_open = (entry_state == E_OPEN);
        exit_gate_open  = (exit_state == X_OPEN);
        if (!rst) begin
            entry_denied = (entry_state == E_CHECK) && !entry_space;
            if (entry_state == E_REPORT) begin
                car_entered        = 1'b1;
                is_uni_car_entered = entry_uni;
            end else if (exit_state == X_REPORT) begin
                car_exited        = 1'b1;
                is_uni_car_exited = exit_uni;
            end
        end
    end

`ifdef GATE_STATS_EN
    logic [16:0] tmo_sum;
    assign tmo_sum = {1'b0, timeout_count} + 17'(entry_timeout) + 17'(exit_timeout);

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            denied_count  <= '0;
            timeout_count <= '0;
        end else begin
            if (entry_denied && denied_count != 16'hFFFF)
                denied_count <= denied_count + 16'(1);
            timeout_count <= tmo_sum[16] ? 16'hFFFF : tmo_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench for parking_gate_controller: stimulus queues expected events, a monitor pops and compares.
`timescale 1ns/1ps

module tb_parking_gate_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic entry_request, entry_is_uni, entry_passed;
    logic exit_request, exit_is_uni, exit_passed;
    logic uni_is_vacated_space, is_vacated_space, is_vac_drive;
    logic entry_gate_open, exit_gate_open, entry_denied;
    logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
`ifdef GATE_STATS_EN
    logic [15:0] denied_count, timeout_count;
`endif

    parking_gate_controller dut (
        .clk                  (clk),
        .rst                  (rst),
        .entry_request        (entry_request),
        .entry_is_uni         (entry_is_uni),
        .entry_passed         (entry_passed),
        .exit_request         (exit_request),
        .exit_is_uni          (exit_is_uni),
        .exit_passed          (exit_passed),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space),
        .entry_gate_open      (entry_gate_open),
        .exit_gate_open       (exit_gate_open),
        .entry_denied         (entry_denied),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited)
`ifdef GATE_STATS_EN
        ,
        .denied_count         (denied_count),
        .timeout_count        (timeout_count)
`endif
    );

    localparam logic [4:0] EV_ENT  = 5'b10000;
    localparam logic [4:0] EV_EUNI = 5'b01000;
    localparam logic [4:0] EV_EXT  = 5'b00100;
    localparam logic [4:0] EV_XUNI = 5'b00010;
    localparam logic [4:0] EV_DEN  = 5'b00001;

    typedef struct {
        logic [4:0]  ev;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          model_on = 1'b0;
    int unsigned pub_count;
    int unsigned c0;

    always @(posedge clk) cyc <= cyc + 1;

    // Occupancy counter model for the public pool.
    always @(posedge clk) begin
        if (rst) pub_count <= 0;
        else if (car_entered && !is_uni_car_entered) pub_count <= pub_count + 1;
    end
    assign is_vacated_space = model_on ? (pub_count < 200) : is_vac_drive;

    // Monitor: every event presented by the DUT must match the head of the queue.
    always @(negedge clk) begin
        logic [4:0] ev;
        exp_t       item;
        if (mon_en) begin
            ev = {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, entry_denied};
            if (ev != 5'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: actual=%b at cycle %0d required=none", ev, cyc);
                end else begin
                    item = exp_q.pop_front();
                    if (ev !== item.ev || cyc != item.cyc) begin
                        errors++;
                        $display("FAIL event: actual=%b at cycle %0d required=%b at cycle %0d",
                                 ev, cyc, item.ev, item.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic [4:0] ev, input int unsigned c);
        exp_t e;
        e.ev  = ev;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic gates(input string name, input logic ent, input logic ext);
        @(negedge clk);
        chk({name, "_entry_gate"}, 32'(entry_gate_open), 32'(ent));
        chk({name, "_exit_gate"}, 32'(exit_gate_open), 32'(ext));
    endtask

    initial begin
        rst = 1'b1;
        entry_request = 1'b0; entry_is_uni = 1'b0; entry_passed = 1'b0;
        exit_request = 1'b0;  exit_is_uni = 1'b0;  exit_passed = 1'b0;
        uni_is_vacated_space = 1'b0; is_vac_drive = 1'b0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_outputs", 32'({entry_gate_open, exit_gate_open, entry_denied, car_entered,
                                  is_uni_car_entered, car_exited, is_uni_car_exited}), 0);
`ifdef GATE_STATS_EN
        chk("reset_denied_count", 32'(denied_count), 0);
        chk("reset_timeout_count", 32'(timeout_count), 0);
`endif

        // Reset while the entry barrier is open: closes next cycle, pass is dropped
        tick();
        entry_request = 1'b1; entry_is_uni = 1'b1; uni_is_vacated_space = 1'b1;
        gates("mrst_c0", 1'b0, 1'b0);
        tick(); entry_request = 1'b0;
        gates("mrst_c1", 1'b0, 1'b0);
        tick();
        gates("mrst_c2", 1'b1, 1'b0);
        tick(); rst = 1'b1; entry_passed = 1'b1;
        gates("mrst_c3", 1'b1, 1'b0);
        tick(); entry_passed = 1'b0;
        gates("mrst_c4", 1'b0, 1'b0);
        tick(); rst = 1'b0;
        gates("mrst_c5", 1'b0, 1'b0);

        // University entry, pass at cycle 5 -> event at cycle 6
        tick();
        c0 = cyc;
        entry_request = 1'b1; entry_is_uni = 1'b1; uni_is_vacated_space = 1'b1;
        push(EV_ENT | EV_EUNI, c0 + 6);
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) tick();
            if (k == 1) begin entry_request = 1'b0; entry_is_uni = 1'b0; end
            entry_passed = (k == 5);
            gates($sformatf("uni_entry_c%0d", k), (k >= 2 && k <= 5), 1'b0);
        end
        uni_is_vacated_space = 1'b0;

        // Public entry with no space: denied in the check cycle
        tick();
        c0 = cyc;
        entry_request = 1'b1; entry_is_uni = 1'b0; is_vac_drive = 1'b0;
        push(EV_DEN, c0 + 1);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) tick();
            if (k == 1) entry_request = 1'b0;
            gates($sformatf("deny_c%0d", k), 1'b0, 1'b0);
        end
`ifdef GATE_STATS_EN
        chk("denied_count_after_deny", 32'(denied_count), 1);
`endif

        // Exit timeout: open 16 cycles, no event
        tick();
        c0 = cyc;
        exit_request = 1'b1; exit_is_uni = 1'b1;
        for (int k = 0; k <= 18; k++) begin
            if (k > 0) tick();
            if (k == 1) exit_request = 1'b0;
            gates($sformatf("exit_tmo_c%0d", k), 1'b0, (k >= 1 && k <= 16));
        end
`ifdef GATE_STATS_EN
        chk("timeout_count_after_exit_tmo", 32'(timeout_count), 1);
`endif

        // Simultaneous passes: entry event first, exit one cycle later
        tick();
        c0 = cyc;
        entry_request = 1'b1; entry_is_uni = 1'b0; is_vac_drive = 1'b1;
        exit_request = 1'b1;  exit_is_uni = 1'b1;
        push(EV_ENT, c0 + 4);
        push(EV_EXT | EV_XUNI, c0 + 5);
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) tick();
            if (k == 1) begin entry_request = 1'b0; exit_request = 1'b0; exit_is_uni = 1'b0; end
            entry_passed = (k == 3);
            exit_passed  = (k == 3);
            gates($sformatf("tie_c%0d", k), (k == 2 || k == 3), (k >= 1 && k <= 3));
        end

        // Pass sensors while idle are ignored
        tick(); entry_passed = 1'b1; exit_passed = 1'b1;
        tick(); entry_passed = 1'b0; exit_passed = 1'b0;
        gates("idle_pass", 1'b0, 1'b0);
        tick(); tick();

        // 200 public entries against a capacity-200 model, the 201st is denied
        tick(); rst = 1'b1; model_on = 1'b1;
        tick(); rst = 1'b0;
        for (int i = 0; i <= 200; i++) begin
            tick();
            c0 = cyc;
            entry_request = 1'b1; entry_is_uni = 1'b0;
            if (i < 200) push(EV_ENT, c0 + 3);
            else         push(EV_DEN, c0 + 1);
            tick(); entry_request = 1'b0;
            tick(); entry_passed = (i < 200);
            tick(); entry_passed = 1'b0;
        end
        tick(); tick();
        @(negedge clk);
        chk("model_public_count", pub_count, 200);
`ifdef GATE_STATS_EN
        chk("denied_count_after_fill", 32'(denied_count), 1);
        chk("timeout_count_after_fill", 32'(timeout_count), 0);
`endif
        chk("pending_expected_events", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
